fft_input_loader: RTL and testbench

Serial-to-parallel front end for the 4-point FFT engine. Accepts one WIDTH-bit signed word per transfer over a valid/ready stream, in interleaved order (real, imag per sample). Assembles a complete 4-sample complex frame and presents all 8 words in parallel to the engine's in_real/in_imag inputs. Holds the frame stable under a valid/ready frame handshake until the downstream consumer takes it.

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_input_loader.sv | 92 +++++++++
 tb/tb_fft_input_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 4-point FFT datapath: word width, frame size,
// the signed sample type and the loader state encoding.
package fft_pkg;

    localparam int WIDTH    = 8;
    localparam int N_POINTS = 4;

    typedef logic signed [WIDTH-1:0] sample_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/fft_input_loader.sv
// Serial-to-parallel loader: collects interleaved real/imag words into a
// 4-sample complex frame and holds it under a valid/ready frame handshake.
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int WIDTH     = fft_pkg::WIDTH,
    parameter int N_POINTS  = fft_pkg::N_POINTS,
    parameter int CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic signed [WIDTH-1:0] frame_real [0:N_POINTS-1],
    output logic signed [WIDTH-1:0] frame_imag [0:N_POINTS-1],
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [2:0]              fill_level,
    output logic [CNT_WIDTH-1:0]    frame_count
);

    state_t                  r_state;
    logic [2:0]              r_fill;
    logic [CNT_WIDTH-1:0]    r_count;
    logic signed [WIDTH-1:0] r_real [N_POINTS];
    logic signed [WIDTH-1:0] r_imag [N_POINTS];

    // A word is taken only in FILL; flush drops the word offered with it.
    logic w_accept;
    assign w_accept = (r_state == FILL) && in_valid && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_fill  <= 3'd0;
            r_count <= '0;
        end else if (flush) begin
            r_state <= FILL;
            r_fill  <= 3'd0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_fill <= r_fill + 3'd1;
                        if (r_fill == 3'd7) begin
                            r_state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (frame_ready) begin
                        r_state <= FILL;
                        r_count <= r_count + 1'b1;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    // Even slots carry the real part of sample slot/2, odd slots the imaginary.
    generate
        for (genvar gi = 0; gi < N_POINTS; gi++) begin : g_sample
            localparam logic [2:0] SLOT_RE = 3'(2 * gi);
            localparam logic [2:0] SLOT_IM = 3'(2 * gi + 1);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_real[gi] <= '0;
                    r_imag[gi] <= '0;
                end else if (flush) begin
                    r_real[gi] <= '0;
                    r_imag[gi] <= '0;
                end else if (w_accept) begin
                    if (r_fill == SLOT_RE) r_real[gi] <= in_data;
                    if (r_fill == SLOT_IM) r_imag[gi] <= in_data;
                end
            end

            assign frame_real[gi] = r_real[gi];
            assign frame_imag[gi] = r_imag[gi];
        end
    endgenerate

    assign in_ready    = (r_state == FILL);
    assign frame_valid = (r_state == FULL);
    assign fill_level  = r_fill;
    assign frame_count = r_count;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed self-checking bench for fft_input_loader.
module tb_fft_input_loader;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic signed [7:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic signed [7:0] frame_real [0:3];
    logic signed [7:0] frame_imag [0:3];
    logic              frame_valid;
    logic              frame_ready = 1'b0;
    logic [2:0]        fill_level;
    logic [7:0]        frame_count;

    int checks = 0;
    int errors = 0;
    logic signed [7:0] vec [0:31];

    fft_input_loader #(.WIDTH(8), .N_POINTS(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .frame_real(frame_real),
        .frame_imag(frame_imag), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .fill_level(fill_level),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int base, input int n);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_data = vec[base + i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (frame_valid !== 1'b0 || fill_level !== 3'd0 || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl got fv=%0b fill=%0d cnt=%0d exp 0 0 0", frame_valid, fill_level, frame_count);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (frame_real[j] !== 8'sd0 || frame_imag[j] !== 8'sd0) begin
                errors++;
                $display("FAIL reset_buf[%0d] got %0d/%0d exp 0/0", j, frame_real[j], frame_imag[j]);
            end
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b exp 1", in_ready);
        end
        $display("reset done");
    endtask

    task automatic test_fill();
        logic signed [7:0] er [4] = '{8'sd10, 8'sd20, -8'sd128, 8'sd127};
        logic signed [7:0] ei [4] = '{-8'sd3, 8'sd4, 8'sd0, -8'sd1};
        vec[0:7] = '{8'sd10, -8'sd3, 8'sd20, 8'sd4, -8'sd128, 8'sd0, 8'sd127, -8'sd1};
        stream(0, 7);
        checks++;
        if (frame_valid !== 1'b0 || fill_level !== 3'd7 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_7 got fv=%0b fill=%0d rdy=%0b exp 0 7 1", frame_valid, fill_level, in_ready);
        end
        stream(7, 1);
        checks++;
        if (frame_valid !== 1'b1 || in_ready !== 1'b0 || fill_level !== 3'd0) begin
            errors++;
            $display("FAIL fill_8 got fv=%0b rdy=%0b fill=%0d exp 1 0 0", frame_valid, in_ready, fill_level);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (frame_real[j] !== er[j] || frame_imag[j] !== ei[j]) begin
                errors++;
                $display("FAIL fill_word[%0d] got %0d/%0d exp %0d/%0d", j, frame_real[j], frame_imag[j], er[j], ei[j]);
            end
        end
        $display("frame loaded: %0d %0d %0d %0d", frame_real[0], frame_real[1], frame_real[2], frame_real[3]);
    endtask

    task automatic test_hold();
        in_valid = 1'b1;
        in_data  = 8'sd55;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (frame_valid !== 1'b1 || in_ready !== 1'b0 || frame_real[0] !== 8'sd10 || frame_imag[3] !== -8'sd1) begin
                errors++;
                $display("FAIL hold_c%0d got fv=%0b rdy=%0b r0=%0d i3=%0d exp 1 0 10 -1", c, frame_valid, in_ready, frame_real[0], frame_imag[3]);
            end
        end
        in_valid    = 1'b0;
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        checks++;
        if (frame_count !== 8'd1 || in_ready !== 1'b1 || fill_level !== 3'd0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL handoff got cnt=%0d rdy=%0b fill=%0d fv=%0b exp 1 1 0 0", frame_count, in_ready, fill_level, frame_valid);
        end
        checks++;
        if (frame_real[0] !== 8'sd10) begin
            errors++;
            $display("FAIL persist got %0d exp 10", frame_real[0]);
        end
        $display("handoff count=%0d", frame_count);
    endtask

    task automatic test_random();
        int idx = 0;
        int f = 0;
        logic acc;
        do_reset();
        for (int i = 0; i < 24; i++) vec[i] = 8'(i * 13 - 50);
        frame_ready = 1'b1;
        for (int c = 0; c < 400 && f < 3; c++) begin
            if (frame_valid) begin
                for (int j = 0; j < 4; j++) begin
                    checks++;
                    if (frame_real[j] !== vec[f*8 + 2*j] || frame_imag[j] !== vec[f*8 + 2*j + 1]) begin
                        errors++;
                        $display("FAIL rand_f%0d_w%0d got %0d/%0d exp %0d/%0d", f, j, frame_real[j], frame_imag[j], vec[f*8 + 2*j], vec[f*8 + 2*j + 1]);
                    end
                end
                $display("random frame %0d seen", f);
                f++;
            end
            in_valid = (idx < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data  = (idx < 24) ? vec[idx] : 8'sd0;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if (f != 3) begin
            errors++;
            $display("FAIL rand_timeout got %0d frames exp 3", f);
        end
        checks++;
        if (frame_count !== 8'd3) begin
            errors++;
            $display("FAIL rand_count got %0d exp 3", frame_count);
        end
        frame_ready = 1'b0;
    endtask

    task automatic test_flush_fill();
        for (int i = 0; i < 13; i++) vec[i] = 8'(i + 1);
        vec[5] = 8'sd99;
        for (int i = 6; i < 14; i++) vec[i] = 8'(i + 15);
        stream(0, 5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = vec[5];
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (fill_level !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_fill_ctrl got fill=%0d rdy=%0b exp 0 1", fill_level, in_ready);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (frame_real[j] !== 8'sd0 || frame_imag[j] !== 8'sd0) begin
                errors++;
                $display("FAIL flush_zero[%0d] got %0d/%0d exp 0/0", j, frame_real[j], frame_imag[j]);
            end
        end
        stream(6, 8);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (frame_real[j] !== 8'(21 + 2*j) || frame_imag[j] !== 8'(22 + 2*j) || frame_valid !== 1'b1) begin
                errors++;
                $display("FAIL post_flush[%0d] got %0d/%0d fv=%0b exp %0d/%0d 1", j, frame_real[j], frame_imag[j], frame_valid, 21 + 2*j, 22 + 2*j);
            end
        end
        $display("flush in FILL, clean frame reloaded");
    endtask

    task automatic test_flush_full();
        logic [7:0] c0;
        c0 = frame_count;
        flush       = 1'b1;
        frame_ready = 1'b1;
        tick();
        flush       = 1'b0;
        frame_ready = 1'b0;
        checks++;
        if (frame_valid !== 1'b0 || frame_count !== c0 || in_ready !== 1'b1 || frame_real[0] !== 8'sd0) begin
            errors++;
            $display("FAIL flush_full got fv=%0b cnt=%0d rdy=%0b r0=%0d exp 0 %0d 1 0", frame_valid, frame_count, in_ready, frame_real[0], c0);
        end
        $display("flush in FULL, count=%0d", frame_count);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) vec[i] = 8'(-20 - 3*i);
        stream(0, 6);
        checks++;
        if (fill_level !== 3'd6) begin
            errors++;
            $display("FAIL pre_areset got fill=%0d exp 6", fill_level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fill_level !== 3'd0 || frame_real[0] !== 8'sd0 || frame_imag[2] !== 8'sd0 || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL areset got fill=%0d r0=%0d i2=%0d cnt=%0d exp 0 0 0 0", fill_level, frame_real[0], frame_imag[2], frame_count);
        end
        #3 rst_n = 1'b1;
        tick();
        stream(0, 8);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (frame_real[j] !== 8'(-20 - 6*j) || frame_imag[j] !== 8'(-23 - 6*j)) begin
                errors++;
                $display("FAIL after_areset[%0d] got %0d/%0d exp %0d/%0d", j, frame_real[j], frame_imag[j], -20 - 6*j, -23 - 6*j);
            end
        end
        $display("async reset mid-frame recovered");
    endtask

    task automatic test_wrap();
        do_reset();
        frame_ready = 1'b1;
        in_valid    = 1'b1;
        in_data     = 8'sd7;
        for (int c = 0; c < 255 * 9; c++) tick();
        checks++;
        if (frame_count !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255 got %0d exp 255", frame_count);
        end
        for (int c = 0; c < 9; c++) tick();
        in_valid    = 1'b0;
        frame_ready = 1'b0;
        checks++;
        if (frame_count !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap_0 got cnt=%0d rdy=%0b exp 0 1", frame_count, in_ready);
        end
        $display("256 frames, count=%0d", frame_count);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hold();
        test_random();
        test_flush_fill();
        test_flush_full();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
